div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle signed integer divider that sits beside the combinational ALU in the datapath. It takes the same operand sources: A from the Y register and B from the bus. Its results go to the downstream Z register pair, with the quotient to ZLo and the remainder to ZHi. Division in the combinational ALU path is slow; DIV instructions issue here instead and stall the control unit on a start/done handshake.

## Interface
- `word_size`, default 32: operand and result width in bits. Must be ≥ 2.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `A`  in  word_size  dividend.
- `B`  in  word_size  divisor.
- `busy`  out  1  high from the edge after `start` is accepted until the edge that raises `done`.
- `done`  out  1  single-cycle pulse; results valid from this cycle on.
- `Quotient`  out  word_size  to ZLo.
- `Remainder`  out  word_size  to ZHi.
- `div_by_zero`  out  1  set with `done` when B was 0; holds until next accepted start.

## Operation
- Reset value of every output is 0; state is IDLE.
- States:
  - IDLE → CALC on `start`=1, B≠0. Latch |A|, |B|, the quotient sign (A[msb]^B[msb]) and the remainder sign (A[msb]). Clear the iteration counter and `div_by_zero`.
  - IDLE → DONE on `start`=1, B=0. Set Quotient=0, Remainder=A, `div_by_zero`=1.
  - CALC: restoring radix-2, one quotient bit per cycle, MSB first. Working remainder is word_size+1 bits. After word_size iterations → FIX.
  - FIX: negate the quotient if the quotient sign is set. Negate the remainder if the remainder sign is set. Register both into the outputs. → DONE.
  - DONE: `done`=1 for this cycle only → IDLE.
- Semantics are truncating division: A = Q·B + R, |R| < |B|, and R takes the sign of A.
- Magnitudes use two's-complement negation in word_size bits. |−2^(word_size−1)| = 2^(word_size−1), treated as an unsigned magnitude.
- Overflow case −2^(word_size−1) / −1: Quotient wraps to 0x80000000 (word_size=32), Remainder=0, no flag.
- `start` outside IDLE, including in DONE, is ignored. There is no queueing.
- Operands are latched at acceptance. Later changes on A/B have no effect on an operation in progress.
- Quotient, Remainder and `div_by_zero` hold their values after DONE until the next accepted start. They do not change during CALC/FIX.
- `clear` in any state returns to IDLE on that edge and zeroes all outputs. An aborted operation never produces `done`.
- `clear` and `start` high on the same edge: `clear` wins and the start is lost.

## Timing
- Let edge N be the edge that samples `start`=1 in IDLE.
- B≠0:
  - `busy` is high from edge N through edge N+word_size+1.
  - CALC occupies edges N+1 … N+word_size. FIX occupies edge N+word_size+1.
  - `done` is high for the cycle after edge N+word_size+1, which is 34 cycles after start for word_size=32.
- B=0: `busy` stays low, and `done` is high for the cycle after edge N, which is 1 cycle after start.
- The earliest next accepted start is the edge ending the `done` cycle plus one, i.e. IDLE must be re-entered first.
- There is no combinational path from inputs to outputs.

## Configuration
- `DIV_SIGNED_EN` defined:
  - Signed two's-complement behaviour as described above.
- `DIV_SIGNED_EN` undefined:
  - A and B are unsigned, and no sign fix is applied in FIX.
  - The FIX state is still traversed, so latency is identical.
  - Overflow is impossible.
  - The B=0 behaviour is unchanged.

## Test plan
- Signed, word_size=32: A=100, B=7, start at N → `done` one cycle after N+33, Quotient=14, Remainder=2, `div_by_zero`=0.
- Signed: A=−100 (0xFFFFFF9C), B=7 → Quotient=0xFFFFFFF2 (−14), Remainder=0xFFFFFFFE (−2). Also A=100, B=−7 → Q=−14, R=2.
- A=0x12345678, B=0 → `done` one cycle after N, `busy` never high, Quotient=0, Remainder=0x12345678, `div_by_zero`=1.
- Signed: A=0x80000000, B=0xFFFFFFFF → Quotient=0x80000000, Remainder=0. Unsigned build with the same inputs → Quotient=0, Remainder=0x80000000.
- Start A=1000, B=3:
  - Pulse `start` again with A=9, B=2 at N+5 → ignored; result is Q=333, R=1.
  - Assert `clear` at N+10 → `busy`=0 and all outputs 0 next cycle, no `done` within 40 cycles.
- Back-to-back: start again on the first IDLE cycle after `done` → accepted. The previous results hold until the new `done`.

Source files
------------

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Multi-cycle integer divider placed beside the combinational ALU. A comes
// from the Y register, B from the bus. The quotient goes to ZLo and the
// remainder to ZHi. The control unit issues DIV with a start pulse and
// stalls until done.
//
// Ports
//   clock        in   sole clock, rising edge
//   clear        in   synchronous active-high reset
//   start        in   division request, sampled only in IDLE
//   A            in   dividend (word_size bits)
//   B            in   divisor  (word_size bits)
//   busy         out  high while an accepted non-zero-divisor operation runs
//   done         out  one-cycle completion pulse
//   Quotient     out  result to ZLo, held until the next result
//   Remainder    out  result to ZHi, held until the next result
//   div_by_zero  out  set with done when B was 0, held until next accepted start
//
// Configuration macro
//   DIV_SIGNED_EN  defined   : signed two's-complement truncating division
//                  undefined : unsigned division, identical latency
//
// Latency for B != 0 is word_size + 2 cycles from the start edge to the done
// cycle: one restoring step per cycle in CALC, then one FIX cycle.
// A zero divisor completes in one cycle without raising busy.
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int word_size = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [word_size-1:0] A,
  input  logic [word_size-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [word_size-1:0] Quotient,
  output logic [word_size-1:0] Remainder,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(word_size);
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(word_size - 1);
  localparam logic [word_size-1:0] ONE_W     = {{(word_size-1){1'b0}}, 1'b1};
  localparam logic [word_size-1:0] ZERO_W    = {word_size{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negation in word_size bits.
  function automatic logic [word_size-1:0] neg2c(input logic [word_size-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Operand magnitude. The most negative value maps onto itself, which is
  // exactly 2^(word_size-1) when read as unsigned.
  function automatic logic [word_size-1:0] mag(input logic [word_size-1:0] v);
`ifdef DIV_SIGNED_EN
    return v[word_size-1] ? neg2c(v) : v;
`else
    return v;
`endif
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [word_size-1:0]   rem_q, rem_d;     // partial remainder, always < divisor
  logic [word_size-1:0]   quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [word_size-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [word_size-1:0]   quotient_q, quotient_d;
  logic [word_size-1:0]   remainder_q, remainder_d;
  logic                   dbz_q, dbz_d;

  // Working remainder is word_size+1 bits: the shifted partial remainder can
  // reach 2*divisor-1. The top bit of the trial difference is the borrow.
  logic [word_size:0]     rem_shift_s;
  logic [word_size:0]     trial_s;

  // Restoring step datapath.
  always_comb begin
    rem_shift_s = {rem_q, quo_q[word_size-1]};
    trial_s     = rem_shift_s - {1'b0, dvs_q};
  end

  // Next-state and next-output computation for the divider FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (B != ZERO_W) begin
            state_d = CALC;
            busy_d  = 1'b1;
            cnt_d   = {CNT_W{1'b0}};
            rem_d   = ZERO_W;
            quo_d   = mag(A);
            dvs_d   = mag(B);
`ifdef DIV_SIGNED_EN
            q_neg_d = A[word_size-1] ^ B[word_size-1];
            r_neg_d = A[word_size-1];
`else
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
`endif
            dbz_d   = 1'b0;
          end else begin
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = ZERO_W;
            remainder_d = A;
            dbz_d       = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (!trial_s[word_size]) begin
          rem_d = trial_s[word_size-1:0];
        end else begin
          rem_d = rem_shift_s[word_size-1:0];
        end
        quo_d = {quo_q[word_size-2:0], ~trial_s[word_size]};
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      FIX: begin
        quotient_d  = q_neg_q ? neg2c(quo_q) : quo_q;
        remainder_d = r_neg_q ? neg2c(rem_q) : rem_q;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; clear wins over everything, including start.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= ZERO_W;
      quo_q       <= ZERO_W;
      dvs_q       <= ZERO_W;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= ZERO_W;
      remainder_q <= ZERO_W;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Quotient    = quotient_q;
  assign Remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//
// Self-checking bench for div_unit (word_size = 32). Table vectors carry
// expected results for both the signed (DIV_SIGNED_EN) and unsigned builds;
// random operations are checked against a 64-bit arithmetic reference model.
// Hand-written sequences cover ignored starts, start in DONE, clear abort,
// and clear/start collision.
// ---------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;
  localparam int CALC_LAT = W + 2;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         div_by_zero;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] prev_q   = '0;
  logic [W-1:0] prev_r   = '0;

  div_unit #(.word_size(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: truncating division computed in 64-bit arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'd0; r = a; dbz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q = W'(sa / sb);
      r = W'(sa % sb);
      dbz = 1'b0;
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input string tag);
    int cyc;
    bit busy_bad, hold_bad;
    A = a; B = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1; busy_bad = 1'b0; hold_bad = 1'b0;
    A = $urandom; B = $urandom;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (Quotient !== prev_q || Remainder !== prev_r || div_by_zero !== 1'b0)
        hold_bad = 1'b1;
      @(negedge clock);
      cyc++;
      A = $urandom; B = $urandom;
    end
    chk({tag, " latency"}, 64'(cyc), (b == 32'd0) ? 64'd1 : 64'(CALC_LAT));
    chk({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    chk({tag, " hold_during"}, 64'(hold_bad), 64'd0);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " Quotient"}, 64'(Quotient), 64'(eq));
    chk({tag, " Remainder"}, 64'(Remainder), 64'(er));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
    @(negedge clock);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " Quotient_hold"}, 64'(Quotient), 64'(eq));
    prev_q = eq; prev_r = er;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic [W-1:0] q_s, r_s;
    logic [W-1:0] q_u, r_u;
    logic         dbz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] ra, rb, mq, mr, eq, er;
    logic mdbz;
    int cyc;
    bit seen;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   32'h24924916,   32'd2,          1'b0};
    vecs[2] = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          32'd0,          32'd100,        1'b0};
    vecs[3] = '{32'h12345678,   32'd0,          32'd0,          32'h12345678,   32'd0,          32'h12345678,   1'b1};
    vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          32'd0,          32'h80000000,   1'b0};
    vecs[5] = '{32'd1000,       32'd3,          32'd333,        32'd1,          32'd333,        32'd1,          1'b0};
    vecs[6] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   32'h7FFFFFFC,   32'd1,          1'b0};
    vecs[7] = '{32'd5,          32'd7,          32'd0,          32'd5,          32'd0,          32'd5,          1'b0};
    vecs[8] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          32'd1,          32'd0,          1'b0};
    vecs[9] = '{32'd7,          32'd1,          32'd7,          32'd0,          32'd7,          32'd0,          1'b0};

    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset Quotient", 64'(Quotient), 64'd0);
    chk("reset Remainder", 64'(Remainder), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    clear = 1'b0;
    @(negedge clock);

    // Table vectors, issued back to back on the first IDLE cycle.
    for (int i = 0; i < 10; i++) begin
`ifdef DIV_SIGNED_EN
      do_div(vecs[i].a, vecs[i].b, vecs[i].q_s, vecs[i].r_s, vecs[i].dbz, $sformatf("vec%0d", i));
`else
      do_div(vecs[i].a, vecs[i].b, vecs[i].q_u, vecs[i].r_u, vecs[i].dbz, $sformatf("vec%0d", i));
`endif
    end

    // Start during CALC is ignored; operands were latched at acceptance.
    A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0; cyc = 1;
    while (cyc < 5) begin @(negedge clock); cyc++; end
    A = 32'd9; B = 32'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0; cyc++;
    A = 32'd0; B = 32'd0;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clock); cyc++; end
    chk("ign latency", 64'(cyc), 64'(CALC_LAT));
    chk("ign Quotient", 64'(Quotient), 64'd333);
    chk("ign Remainder", 64'(Remainder), 64'd1);
    // Start held during the DONE cycle is ignored too.
    A = 32'd50; B = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("done_start busy", 64'(busy), 64'd0);
    @(negedge clock);
    chk("done_start busy2", 64'(busy), 64'd0);
    chk("done_start done", 64'(done), 64'd0);
    chk("done_start Quotient", 64'(Quotient), 64'd333);

    // Clear mid-operation aborts without done and zeroes outputs.
    A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0; cyc = 1;
    while (cyc < 10) begin @(negedge clock); cyc++; end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort Quotient", 64'(Quotient), 64'd0);
    chk("abort Remainder", 64'(Remainder), 64'd0);
    chk("abort div_by_zero", 64'(div_by_zero), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("abort no_done", 64'(seen), 64'd0);
    prev_q = '0; prev_r = '0;

    // Clear and start on the same edge: the start is lost.
    A = 32'd0; B = 32'd0; start = 1'b1; clear = 1'b1;
    @(negedge clock);
    start = 1'b0; clear = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1 || busy === 1'b1 || div_by_zero === 1'b1) seen = 1'b1;
      @(negedge clock);
    end
    chk("clear_start lost", 64'(seen), 64'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        3: ra = 32'h80000000;
        4: rb = rb >> $urandom_range(0, 31);
        default: ra = ra;
      endcase
      model(ra, rb, mq, mr, mdbz);
      do_div(ra, rb, mq, mr, mdbz, $sformatf("rnd%0d", n));
    end

    // Model cross-check on the table's own boundary vector.
    model(32'h80000000, 32'hFFFFFFFF, eq, er, mdbz);
`ifdef DIV_SIGNED_EN
    chk("model overflow q", 64'(eq), 64'h80000000);
`else
    chk("model overflow q", 64'(eq), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
